// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing: pixel-rate divider, h/v counters, registered sync/visible
// decode and frame/animation strobes, all frozen while en is low.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_VIS_START     = 144,
  parameter int unsigned H_VIS_END       = 783,
  parameter int unsigned V_TOTAL         = 521,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_VIS_START     = 31,
  parameter int unsigned V_VIS_END       = 510,
  parameter int unsigned FRAMES_PER_TICK = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_en,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       frame_start,
  output logic       anim_tick,
  output logic       anim_level
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FrmW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;

  localparam logic [DivW-1:0] DivMax   = DivW'(CLK_DIV - 1);
  localparam logic [FrmW-1:0] FrmMax   = FrmW'(FRAMES_PER_TICK - 1);
  localparam logic [9:0]      HMax     = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VMax     = 10'(V_TOTAL - 1);
  localparam logic [9:0]      HSyncEnd = 10'(H_SYNC);
  localparam logic [9:0]      VSyncEnd = 10'(V_SYNC);
  localparam logic [9:0]      HVisLo   = 10'(H_VIS_START);
  localparam logic [9:0]      HVisHi   = 10'(H_VIS_END);
  localparam logic [9:0]      VVisLo   = 10'(V_VIS_START);
  localparam logic [9:0]      VVisHi   = 10'(V_VIS_END);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            visible_q, visible_d;
  logic            frame_start_q, frame_start_d;
  logic            anim_tick_q, anim_tick_d;
  logic [FrmW-1:0] frm_q, frm_d;
  logic            level_q, level_d;
  logic            line_end, frame_end;

  assign pix_en    = en && (div_q == DivMax);
  assign line_end  = (h_q == HMax);
  assign frame_end = line_end && (v_q == VMax);

  // Strobes are gated by en so a pulse landing in a frozen cycle is held, not lost.
  assign frame_start = frame_start_q & en;
  assign anim_tick   = anim_tick_q & en;

  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = (div_q == DivMax) ? '0 : div_q + DivW'(1);
    end
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (!line_end) begin
        h_d = h_q + 10'd1;
      end else begin
        h_d = '0;
        v_d = (v_q == VMax) ? '0 : v_q + 10'd1;
      end
    end
  end

  // Decode from next-state counters so sync/visible land on the same edge as the counters.
  always_comb begin
    hsync_d   = (h_d >= HSyncEnd);
    vsync_d   = (v_d >= VSyncEnd);
    visible_d = (h_d >= HVisLo) && (h_d <= HVisHi) && (v_d >= VVisLo) && (v_d <= VVisHi);
  end

  always_comb begin
    frm_d   = frm_q;
    level_d = level_q;
    if (frame_start) begin
      frm_d   = anim_tick ? '0 : frm_q + FrmW'(1);
      level_d = level_q ^ anim_tick;
    end
  end

  always_comb begin
    frame_start_d = frame_start_q;
    anim_tick_d   = anim_tick_q;
    if (en) begin
      frame_start_d = pix_en && frame_end;
      anim_tick_d   = pix_en && frame_end && (frm_d == FrmMax);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      visible_q     <= 1'b0;
      frame_start_q <= 1'b0;
      anim_tick_q   <= 1'b0;
      frm_q         <= '0;
      level_q       <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      frame_start_q <= frame_start_d;
      anim_tick_q   <= anim_tick_d;
      frm_q         <= frm_d;
      level_q       <= level_d;
    end
  end

  assign h_count    = h_q;
  assign v_count    = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign visible    = visible_q;
  assign anim_level = level_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster; expected outputs come from a model
// driven by the count of enabled clocks since reset, queued per cycle and compared.
module tb_vga_timing_gen;

  localparam int unsigned CD   = 2;
  localparam int unsigned HT   = 40;
  localparam int unsigned HS   = 6;
  localparam int unsigned HVS  = 9;
  localparam int unsigned HVE  = 36;
  localparam int unsigned VT   = 25;
  localparam int unsigned VS   = 2;
  localparam int unsigned VVS  = 3;
  localparam int unsigned VVE  = 22;
  localparam int unsigned FPT  = 4;
  localparam int unsigned FCLK = CD * HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       pix_en;
  logic [9:0] h_count, v_count;
  logic       hsync, vsync, visible, frame_start, anim_tick, anim_level;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_VIS_START(HVS), .H_VIS_END(HVE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_VIS_START(VVS), .V_VIS_END(VVE), .FRAMES_PER_TICK(FPT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pix_en), .h_count(h_count),
    .v_count(v_count), .hsync(hsync), .vsync(vsync), .visible(visible),
    .frame_start(frame_start), .anim_tick(anim_tick), .anim_level(anim_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Enabled clock edges since reset; every expected output is a function of this.
  int unsigned e = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else if (en) e <= e + 1;
  end

  function automatic logic [26:0] model(input int unsigned ec, input logic en_v);
    int unsigned p, h, v, k, nf;
    logic pe, hs, vs, vis, fs, at, lvl;
    p   = ec / CD;
    h   = p % HT;
    v   = (p / HT) % VT;
    pe  = en_v && ((ec % CD) == CD - 1);
    hs  = (h >= HS);
    vs  = (v >= VS);
    vis = (h >= HVS) && (h <= HVE) && (v >= VVS) && (v <= VVE);
    fs  = en_v && (ec > 0) && (ec % FCLK == 0);
    k   = ec / FCLK;
    at  = fs && (k % FPT == 0);
    nf  = (ec > 0) ? (ec - 1) / FCLK : 0;
    lvl = ((nf / FPT) % 2) == 1;
    return {pe, 10'(h), 10'(v), hs, vs, vis, fs, at, lvl};
  endfunction

  logic [26:0] got_vec;
  assign got_vec = {pix_en, h_count, v_count, hsync, vsync, visible, frame_start, anim_tick,
                    anim_level};

  logic [26:0] sb_q[$];

  always @(negedge clk) sb_q.push_back(model(e, en));

  int fs_count = 0;
  int tick_count = 0;
  int tick_at[4];
  logic level_at_fs[16];
  int en_cyc = 0;
  int last_fs_en = -1;
  logic prev_fs = 1'b0;
  logic [9:0] prev_h = '0, prev_v = '0;

  always @(negedge clk) begin
    logic [26:0] exp_vec;
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      exp_vec = sb_q.pop_front();
      check("cycle_outputs", 32'(got_vec), 32'(exp_vec));
    end
    if (!rst_n) last_fs_en = -1;
    if (en && rst_n) en_cyc++;
    if (frame_start) begin
      fs_count++;
      check("fs_width", 32'(prev_fs), 0);
      check("wrap_from", {prev_h, prev_v}, {10'(HT - 1), 10'(VT - 1)});
      check("wrap_to", {h_count, v_count}, 0);
      if (last_fs_en >= 0) check("fs_spacing", en_cyc - last_fs_en, FCLK);
      last_fs_en = en_cyc;
      if (fs_count < 16) level_at_fs[fs_count] = anim_level;
    end
    if (anim_tick) begin
      check("tick_with_fs", 32'(frame_start), 1);
      if (tick_count < 4) tick_at[tick_count] = fs_count;
      tick_count++;
    end
    prev_fs = frame_start;
    prev_h  = h_count;
    prev_v  = v_count;
  end

  task automatic wait_fs(input int target, input int bound);
    int n = 0;
    while (fs_count < target && n < bound) begin
      @(negedge clk); #2;
      n++;
    end
    if (fs_count < target) check("fs_timeout", 32'(fs_count), 32'(target));
  endtask

  task automatic wait_hv(input int h, input int v, input int bound);
    int n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!(h_count == 10'(h) && v_count == 10'(v) && !pix_en) && n < bound);
    if (!(h_count == 10'(h) && v_count == 10'(v))) check("hv_timeout", {h_count, v_count},
                                                          {10'(h), 10'(v)});
  endtask

  initial begin
    int n;
    int fs_snap;
    logic [9:0] hold_h, hold_v;
    logic hold_hs, hold_vis;

    // Reset held with en high: everything stays zero.
    repeat (5) begin
      @(negedge clk); #2;
      check("reset_outputs", 32'(got_vec), 0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;

    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!pix_en && n < 10);
    check("first_pix_en_cycle", n, CD);
    @(negedge clk); #2;
    check("h_after_first_pix", 32'(h_count), 1);

    wait_fs(3, 4 * FCLK);
    repeat (5) @(negedge clk);
    #2;
    check("three_frames", fs_count, 3);

    wait_fs(9, 7 * FCLK);
    repeat (5) @(negedge clk);
    #2;
    check("nine_frames", fs_count, 9);
    check("tick_count", tick_count, 2);
    check("tick_first", tick_at[0], 4);
    check("tick_second", tick_at[1], 8);
    check("level_at_fs4", 32'(level_at_fs[4]), 0);
    check("level_at_fs5", 32'(level_at_fs[5]), 1);
    check("level_at_fs8", 32'(level_at_fs[8]), 1);
    check("level_at_fs9", 32'(level_at_fs[9]), 0);

    // Freeze mid-frame for 17 clocks.
    wait_hv(30, 12, 2 * FCLK);
    @(posedge clk); #2;
    en = 1'b0;
    @(negedge clk); #2;
    hold_h = h_count; hold_v = v_count; hold_hs = hsync; hold_vis = visible;
    check("hold_start_h", 32'(hold_h), 30);
    fs_snap = fs_count;
    repeat (16) begin
      @(negedge clk); #2;
      check("hold_h", 32'(h_count), 32'(hold_h));
      check("hold_v", 32'(v_count), 32'(hold_v));
      check("hold_sync_vis", {hsync, visible}, {hold_hs, hold_vis});
      check("hold_strobes", {pix_en, frame_start, anim_tick}, 0);
    end
    @(posedge clk); #2;
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!pix_en && n < 10);
    check("resume_pix_en", 32'(pix_en), 1);
    @(negedge clk); #2;
    check("resume_h", 32'(h_count), 31);
    check("hold_no_fs", fs_count, fs_snap);

    // Asynchronous reset between edges.
    wait_hv(20, 5, 2 * FCLK);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(got_vec), 0);
    fs_snap = fs_count;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    #2;
    check("no_fs_after_reset", fs_count, fs_snap);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
